// File: rtl/adder_pkg.sv
// Shared constants and types for the ripple-carry adder family.
package adder_pkg;

  localparam int WIDTH_MAX = 64;

  typedef struct packed {
    logic                 carry;
    logic [WIDTH_MAX-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: the ripple stage chained by full_adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational result and a registered
// copy (sum, carry-out, signed overflow) for pipelined consumers.
module full_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] sum_q,
  output logic             c_out_q,
  output logic             ovf_q
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("full_adder: WIDTH out of range 1..WIDTH_MAX");
  end

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_carry[i]),
      .s    (w_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  // At WIDTH=1 the lower carry is c_in itself.
  assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  assign sum   = w_sum;
  assign c_out = w_carry[WIDTH];

  logic [WIDTH-1:0] r_sum_q;
  logic             r_c_out_q;
  logic             r_ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_q   <= '0;
      r_c_out_q <= 1'b0;
      r_ovf_q   <= 1'b0;
    end else begin
      r_sum_q   <= w_sum;
      r_c_out_q <= w_carry[WIDTH];
      r_ovf_q   <= w_ovf;
    end
  end

  assign sum_q   = r_sum_q;
  assign c_out_q = r_c_out_q;
  assign ovf_q   = r_ovf_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: WIDTH=1/8/64 instances, hand vectors, reset sequences
// and random stimulus against an arithmetic reference model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [0:0]  a1, b1, s1, sq1;
  logic        c1, co1, coq1, ov1;
  logic [7:0]  a8, b8, s8, sq8;
  logic        c8, co8, coq8, ov8;
  logic [63:0] a64, b64, s64, sq64;
  logic        c64, co64, coq64, ov64;

  full_adder #(.WIDTH(1)) dut1 (
    .a(a1), .b(b1), .c_in(c1), .sum(s1), .c_out(co1),
    .clk(clk), .rst(rst), .sum_q(sq1), .c_out_q(coq1), .ovf_q(ov1));
  full_adder #(.WIDTH(8)) dut8 (
    .a(a8), .b(b8), .c_in(c8), .sum(s8), .c_out(co8),
    .clk(clk), .rst(rst), .sum_q(sq8), .c_out_q(coq8), .ovf_q(ov8));
  full_adder #(.WIDTH(64)) dut64 (
    .a(a64), .b(b64), .c_in(c64), .sum(s64), .c_out(co64),
    .clk(clk), .rst(rst), .sum_q(sq64), .c_out_q(coq64), .ovf_q(ov64));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned add for sum/carry, signed range test for overflow.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic c, input int w,
                                output logic [63:0] s, output logic co, output logic ov);
    logic [64:0] full, mask;
    logic signed [66:0] sa, sb, r, lim;
    mask = (65'd1 << w) - 65'd1;
    full = {1'b0, a} + {1'b0, b} + {64'd0, c};
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    sa   = $signed({3'b000, a});
    sb   = $signed({3'b000, b});
    if (a[w-1]) sa = sa - (67'sd1 <<< w);
    if (b[w-1]) sb = sb - (67'sd1 <<< w);
    r    = sa + sb + $signed({66'd0, c});
    lim  = 67'sd1 <<< (w - 1);
    ov   = (r >= lim) || (r < -lim);
  endfunction

  typedef struct {
    logic [7:0] a, b;
    logic       c;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;

  vec_t v1[8];
  vec_t v8[8];

  initial begin
    logic [63:0] es;
    logic eco, eov, er;
    logic [63:0] m8, m64;
    logic [63:0] es1, es8, es64;
    logic eco1, eco8, eco64, eov1, eov8, eov64;

    v1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    v1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1};
    v1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0};
    v1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
    v1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    v1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
    v1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1};
    v1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};

    v8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    v8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v8[2] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    v8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    v8[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    v8[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    v8[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    v8[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1;
    a1 = '0; b1 = '0; c1 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    a64 = '0; b64 = '0; c64 = 1'b0;

    @(posedge clk); #1;
    chk("rst_sum_q1", sq1, 0);   chk("rst_cout_q1", coq1, 0);  chk("rst_ovf_q1", ov1, 0);
    chk("rst_sum_q8", sq8, 0);   chk("rst_cout_q8", coq8, 0);  chk("rst_ovf_q8", ov8, 0);
    chk("rst_sum_q64", sq64, 0); chk("rst_cout_q64", coq64, 0); chk("rst_ovf_q64", ov64, 0);

    // Combinational path must respond with no clock edge: apply mid-cycle.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    #2;
    chk("w1_nocl_sum", s1, 0); chk("w1_nocl_cout", co1, 1);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    #1;
    chk("w1_111_sum", s1, 1); chk("w1_111_cout", co1, 1);
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    #1;
    chk("w1_010_sum", s1, 1); chk("w1_010_cout", co1, 0);
    chk("w1_rst_holds_q", sq1, 0);

    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = v1[i].a[0:0]; b1 = v1[i].b[0:0]; c1 = v1[i].c;
      #2;
      chk($sformatf("w1_v%0d_sum", i), s1, v1[i].s[0]);
      chk($sformatf("w1_v%0d_cout", i), co1, v1[i].co);
      @(posedge clk); #1;
      chk($sformatf("w1_v%0d_sum_q", i), sq1, v1[i].s[0]);
      chk($sformatf("w1_v%0d_cout_q", i), coq1, v1[i].co);
      chk($sformatf("w1_v%0d_ovf_q", i), ov1, v1[i].ov);
    end

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a8 = v8[i].a; b8 = v8[i].b; c8 = v8[i].c;
      #2;
      chk($sformatf("w8_v%0d_sum", i), s8, v8[i].s);
      chk($sformatf("w8_v%0d_cout", i), co8, v8[i].co);
      @(posedge clk); #1;
      chk($sformatf("w8_v%0d_sum_q", i), sq8, v8[i].s);
      chk($sformatf("w8_v%0d_cout_q", i), coq8, v8[i].co);
      chk($sformatf("w8_v%0d_ovf_q", i), ov8, v8[i].ov);
    end

    // Reset held across an edge while inputs change: reset wins for *_q only.
    @(negedge clk);
    rst = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b0;
    @(posedge clk); #1;
    chk("rst8_sum_q", sq8, 0); chk("rst8_cout_q", coq8, 0); chk("rst8_ovf_q", ov8, 0);
    chk("rst8_sum", s8, 8'hFE); chk("rst8_cout", co8, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel8_sum_q", sq8, 8'hFE); chk("rel8_cout_q", coq8, 1); chk("rel8_ovf_q", ov8, 0);

    m8 = 64'hFF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      er  = ($urandom_range(0, 9) == 0);
      rst = er;
      a1  = 1'($urandom);  b1 = 1'($urandom);  c1 = 1'($urandom);
      a8  = 8'($urandom);  b8 = 8'($urandom);  c8 = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin a64 = '1; b64 = 64'($urandom); end
        1: begin a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = {32'd0, $urandom}; end
        default: begin a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; end
      endcase
      c64 = 1'($urandom);
      model({63'd0, a1}, {63'd0, b1}, c1, 1, es1, eco1, eov1);
      model({56'd0, a8}, {56'd0, b8}, c8, 8, es8, eco8, eov8);
      model(a64, b64, c64, 64, es64, eco64, eov64);
      #2;
      chk("rnd1_sum", s1, es1[0]);    chk("rnd1_cout", co1, eco1);
      chk("rnd8_sum", s8, es8 & m8);  chk("rnd8_cout", co8, eco8);
      chk("rnd64_sum", s64, es64);    chk("rnd64_cout", co64, eco64);
      @(posedge clk); #1;
      chk("rnd1_sum_q", sq1, er ? 64'd0 : es1);
      chk("rnd1_cout_q", coq1, er ? 1'b0 : eco1);
      chk("rnd1_ovf_q", ov1, er ? 1'b0 : eov1);
      chk("rnd8_sum_q", sq8, er ? 64'd0 : es8);
      chk("rnd8_cout_q", coq8, er ? 1'b0 : eco8);
      chk("rnd8_ovf_q", ov8, er ? 1'b0 : eov8);
      chk("rnd64_sum_q", sq64, er ? 64'd0 : es64);
      chk("rnd64_cout_q", coq64, er ? 1'b0 : eco64);
      chk("rnd64_ovf_q", ov64, er ? 1'b0 : eov64);
    end

    es = '0; eco = 1'b0; eov = 1'b0; m64 = '1;
    model(m64, 64'd1, 1'b0, 64, es, eco, eov);
    @(negedge clk);
    rst = 1'b0; a64 = m64; b64 = 64'd1; c64 = 1'b0;
    @(posedge clk); #1;
    chk("w64_wrap_sum_q", sq64, es); chk("w64_wrap_cout_q", coq64, eco);
    chk("w64_wrap_ovf_q", ov64, eov);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Parameterizable ripple-carry adder: sums two WIDTH-bit operands plus a carry-in. It exposes a combinational result for immediate use and a registered copy for pipelined consumers. It is the leaf arithmetic block of the datapath: instantiated wherever a bit-level or small-word add is needed, and used standalone as the 1-bit full adder at the default WIDTH=1.

## Interface
- WIDTH, default 1: operand width in bits, legal range 1 to 64.
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry-in.
- sum  output  WIDTH  combinational sum, a + b + c_in modulo 2^WIDTH.
- c_out  output  1  combinational carry-out, bit WIDTH of a + b + c_in.
- sum_q  output  WIDTH  sum registered on clk.
- c_out_q  output  1  c_out registered on clk.
- ovf_q  output  1  registered signed-overflow flag for two's-complement interpretation.
- Positional port order in the declaration is fixed: a, b, c_in, sum, c_out, clk, rst, sum_q, c_out_q, ovf_q. Legacy positional instantiations use the first five ports only.

## Operation
- Per bit i:
  - sum[i] = a[i] ^ b[i] ^ carry[i]
  - carry[i+1] = (a[i]&b[i]) | (a[i]&carry[i]) | (b[i]&carry[i])
  - carry[0] = c_in; c_out = carry[WIDTH].
- Result width is WIDTH+1 ({c_out, sum}); no truncation other than the split into sum and c_out.
- ovf = carry[WIDTH] ^ carry[WIDTH-1]. At WIDTH=1, carry[0] is c_in.
- sum and c_out are purely combinational:
  - No dependence on clk or rst.
  - Valid whenever inputs are stable; reset never forces them.
- Registered path: on each rising clk edge, sum_q <= sum, c_out_q <= c_out, ovf_q <= ovf.
- Reset: when rst=1 at a rising edge, sum_q=0, c_out_q=0 and ovf_q=0; combinational outputs are unaffected.
- X/Z on any input may propagate to the outputs; no masking.

## Timing
- Combinational outputs: zero-cycle latency. They settle within one propagation delay of any input change, with no clock required.
- Registered outputs: one-cycle latency. Inputs sampled at edge N appear on *_q after edge N.
- rst asserted mid-stream clears *_q at that edge. The first non-reset edge captures the current inputs.
- rst and an input change in the same cycle: reset wins for *_q.
- No handshake and no stall; every edge captures.
- Reset values: sum_q=0, c_out_q=0, ovf_q=0. sum and c_out have no reset value.

## Structure
- Sub-module full_adder_cell: 1-bit (a, b, cin) to (s, cout). Instantiated WIDTH times in a generate loop to form the ripple chain.
- The shared package adder_pkg holds:
  - the WIDTH_MAX = 64 constant;
  - a typedef for the {carry, sum} result struct.
- The top level holds only the generate chain, the overflow XOR and the output register block.

## Test plan
- WIDTH=1, a=1, b=1, c_in=0 -> sum=0, c_out=1 within 5 time units, with no clock edge needed.
- WIDTH=1, a=1, b=1, c_in=1 -> sum=1, c_out=1. Then a=0, b=1, c_in=0 -> sum=1, c_out=0.
- WIDTH=1, exhaustive 8 input combinations -> {c_out, sum} equals a+b+c_in each time.
- WIDTH=8, a=8'hFF, b=8'h00, c_in=1 -> sum=8'h00, c_out=1. On the next clk edge: sum_q=8'h00, c_out_q=1, ovf_q=0.
- WIDTH=8, a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, c_out=0. After one edge: ovf_q=1.
- Reset: hold rst=1 across an edge with a=b=8'hFF -> *_q=0 while sum=8'hFE, c_out=1. Release rst -> the next edge loads sum_q=8'hFE, c_out_q=1.
